// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// seg7_pkg
// Shared 7-segment patterns, code values and helpers for the capture encoder.
// Revision: 1.0
// ============================================================================
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // Segment order {a,b,c,d,e,f,g}
    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110010;
    localparam seg_t SEG_7_ALT = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_9_ALT = 7'b1110011;
    localparam seg_t SEG_BLANK = 7'b0000000;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_capture_encoder_if.sv
`default_nettype none
// ============================================================================
// seg7_capture_encoder_if
// Multiplexed segment bus in, published-digit valid/ready stream out.
// Revision: 1.0
// ============================================================================
interface seg7_capture_encoder_if #(
    parameter int NUM_DIGITS = 4
);
    import seg7_pkg::*;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    seg_t                  seg_in;
    logic [NUM_DIGITS-1:0] dig_sel;
    logic                  seg_strobe;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDX_W-1:0]      out_idx;
    logic [3:0]            out_bcd;
    logic                  out_err;
    logic                  sel_err;

    modport master (
        output seg_in, dig_sel, seg_strobe, out_ready,
        input  out_valid, out_idx, out_bcd, out_err, sel_err
    );

    modport slave (
        input  seg_in, dig_sel, seg_strobe, out_ready,
        output out_valid, out_idx, out_bcd, out_err, sel_err
    );
endinterface
`default_nettype wire

// File: rtl/seg7_pattern_encode.sv
`default_nettype none
// ============================================================================
// seg7_pattern_encode
// Combinational 7-segment pattern to BCD / blank / error code.
// Revision: 1.0
// ============================================================================
module seg7_pattern_encode
    import seg7_pkg::*;
(
    input  seg_t       seg,
    output logic [3:0] code
);
    always_comb begin
        case (seg)
            SEG_0:             code = 4'd0;
            SEG_1:             code = 4'd1;
            SEG_2:             code = 4'd2;
            SEG_3:             code = 4'd3;
            SEG_4:             code = 4'd4;
            SEG_5:             code = 4'd5;
            SEG_6:             code = 4'd6;
            SEG_7, SEG_7_ALT:  code = 4'd7;
            SEG_8:             code = 4'd8;
            SEG_9, SEG_9_ALT:  code = 4'd9;
            SEG_BLANK:         code = CODE_BLANK;
            default:           code = CODE_ERR;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/seg7_capture_encoder.sv
`default_nettype none
// ============================================================================
// seg7_capture_encoder
// Samples a multiplexed 7-segment bus, debounces each digit and publishes
// changes on a valid/ready stream. SEG7_ACTIVE_LOW_EN inverts seg_in.
// Revision: 1.0
// ============================================================================
module seg7_capture_encoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int STABLE_SCANS = 3
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    seg7_capture_encoder_if.slave  bus
);
    localparam int         IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [3:0] c_STABLE = 4'(STABLE_SCANS);

    seg_t             w_seg;
    logic [3:0]       w_code;
    logic             w_onehot;
    logic [IDX_W-1:0] w_sel_idx;

`ifdef SEG7_ACTIVE_LOW_EN
    assign w_seg = ~bus.seg_in;
`else
    assign w_seg = bus.seg_in;
`endif

    seg7_pattern_encode u_encode (.seg(w_seg), .code(w_code));

    assign w_onehot = is_onehot(8'(bus.dig_sel));

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (bus.dig_sel[i]) w_sel_idx = IDX_W'(i);
    end

    // Stage 1: sample and encode
    logic             r_s1_valid;
    logic [3:0]       r_s1_code;
    logic [IDX_W-1:0] r_s1_idx;
    logic             r_sel_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= 4'd0;
            r_s1_idx   <= '0;
            r_sel_err  <= 1'b0;
        end else begin
            r_s1_valid <= bus.seg_strobe && w_onehot;
            r_sel_err  <= bus.seg_strobe && !w_onehot;
            if (bus.seg_strobe && w_onehot) begin
                r_s1_code <= w_code;
                r_s1_idx  <= w_sel_idx;
            end
        end
    end

    // Stage 2: per-digit stability tracking and pending flags
    logic [3:0] r_cand     [NUM_DIGITS];
    logic [3:0] r_cnt      [NUM_DIGITS];
    logic [3:0] r_last     [NUM_DIGITS];
    logic [3:0] r_pend_val [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_pend;

    logic [3:0] w_next_cnt;
    logic       w_fire;

    always_comb begin
        if (r_s1_code == r_cand[r_s1_idx])
            w_next_cnt = (r_cnt[r_s1_idx] == c_STABLE) ? c_STABLE : r_cnt[r_s1_idx] + 4'd1;
        else
            w_next_cnt = 4'd1;
        w_fire = r_s1_valid && (w_next_cnt == c_STABLE) && (r_s1_code != r_last[r_s1_idx]);
    end

    // Output stage: round-robin over pending digits, starting after last grant
    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_idx;
    logic [3:0]       r_out_bcd;
    logic             r_out_err;
    logic [IDX_W-1:0] r_ptr;

    logic             w_load;
    logic             w_any;
    logic [IDX_W-1:0] w_grant;

    assign w_load = !r_out_valid || bus.out_ready;

    always_comb begin
        w_any   = 1'b0;
        w_grant = r_ptr;
        // Descending scan so the nearest index after r_ptr wins
        for (int k = NUM_DIGITS; k >= 1; k--) begin
            if (r_pend[(int'(r_ptr) + k) % NUM_DIGITS]) begin
                w_any   = 1'b1;
                w_grant = IDX_W'((int'(r_ptr) + k) % NUM_DIGITS);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_cand[i]     <= CODE_BLANK;
                r_cnt[i]      <= 4'd0;
                r_last[i]     <= CODE_BLANK;
                r_pend_val[i] <= CODE_BLANK;
            end
            r_pend      <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_bcd   <= 4'd0;
            r_out_err   <= 1'b0;
            r_ptr       <= '0;
        end else begin
            if (r_s1_valid) begin
                r_cand[r_s1_idx] <= r_s1_code;
                r_cnt[r_s1_idx]  <= w_next_cnt;
            end
            if (w_load && w_any)
                r_pend[w_grant] <= 1'b0;
            // Placed after the clear so a same-cycle set takes precedence
            if (w_fire) begin
                r_pend[r_s1_idx]     <= 1'b1;
                r_pend_val[r_s1_idx] <= r_s1_code;
                r_last[r_s1_idx]     <= r_s1_code;
            end
            if (w_load) begin
                r_out_valid <= w_any;
                if (w_any) begin
                    r_out_idx <= w_grant;
                    r_out_bcd <= r_pend_val[w_grant];
                    r_out_err <= (r_pend_val[w_grant] == CODE_ERR);
                    r_ptr     <= w_grant;
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_bcd   = r_out_bcd;
    assign bus.out_err   = r_out_err;
    assign bus.sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture_encoder.sv
`default_nettype none
// ============================================================================
// tb_seg7_capture_encoder
// Directed self-checking bench for seg7_capture_encoder (NUM_DIGITS=4, STABLE_SCANS=3).
// Revision: 1.0
// ============================================================================
module tb_seg7_capture_encoder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   c3;

    int q_idx[$];
    int q_bcd[$];
    int q_err[$];
    int q_cyc[$];

    seg7_capture_encoder_if #(.NUM_DIGITS(4)) bus ();

    seg7_capture_encoder #(.NUM_DIGITS(4), .STABLE_SCANS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Handshake occurs at the next rising edge; values are stable at the falling edge
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            q_idx.push_back(int'(bus.out_idx));
            q_bcd.push_back(int'(bus.out_bcd));
            q_err.push_back(int'(bus.out_err));
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input int idx, input logic [6:0] pat);
        @(posedge clk); #2;
        bus.seg_in     = pat;
        bus.dig_sel    = 4'(1 << idx);
        bus.seg_strobe = 1'b1;
    endtask

    task automatic idle();
        @(posedge clk); #2;
        bus.seg_strobe = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_q();
        q_idx.delete(); q_bcd.delete(); q_err.delete(); q_cyc.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_idx"},   32'(bus.out_idx),   0);
        check({tag, "_bcd"},   32'(bus.out_bcd),   0);
        check({tag, "_err"},   32'(bus.out_err),   0);
        check({tag, "_selerr"}, 32'(bus.sel_err),  0);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b0;
        bus.seg_in = 7'd0; bus.dig_sel = 4'd0; bus.seg_strobe = 1'b0; bus.out_ready = 1'b1;
        wait_cycles(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        wait_cycles(2);

        // 1: digit 0 shows "3" three times
        clear_q();
        strobe(0, 7'b1111001);
        strobe(0, 7'b1111001);
        strobe(0, 7'b1111001);
        c3 = cyc;
        idle();
        wait_cycles(6);
        check("t1_count", 32'(q_idx.size()), 1);
        if (q_idx.size() >= 1) begin
            check("t1_idx", 32'(q_idx[0]), 0);
            check("t1_bcd", 32'(q_bcd[0]), 3);
            check("t1_err", 32'(q_err[0]), 0);
            check("t1_latency", 32'(q_cyc[0]), 32'(c3 + 3));
        end
        strobe(0, 7'b1111001);
        idle();
        wait_cycles(6);
        check("t1_no_repeat", 32'(q_idx.size()), 1);

        // 2: digit 1 flickers 5,5 then settles on 8
        clear_q();
        strobe(1, 7'b1011011);
        strobe(1, 7'b1011011);
        strobe(1, 7'b1111111);
        strobe(1, 7'b1111111);
        strobe(1, 7'b1111111);
        idle();
        wait_cycles(6);
        check("t2_count", 32'(q_idx.size()), 1);
        if (q_idx.size() >= 1) begin
            check("t2_idx", 32'(q_idx[0]), 1);
            check("t2_bcd", 32'(q_bcd[0]), 8);
        end

        // 3: digit 2 invalid pattern, then blank
        clear_q();
        repeat (3) strobe(2, 7'b1000001);
        idle();
        wait_cycles(6);
        repeat (3) strobe(2, 7'b0000000);
        idle();
        wait_cycles(6);
        check("t3_count", 32'(q_idx.size()), 2);
        if (q_idx.size() >= 2) begin
            check("t3_bcd_err", 32'(q_bcd[0]), 32'hE);
            check("t3_err_flag", 32'(q_err[0]), 1);
            check("t3_bcd_blank", 32'(q_bcd[1]), 32'hF);
            check("t3_blank_err", 32'(q_err[1]), 0);
            check("t3_idx", 32'(q_idx[1]), 2);
        end

        // 4: backpressure with four digits pending, then drain
        clear_q();
        bus.out_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            strobe(0, 7'b1110010);
            strobe(1, 7'b0110000);
            strobe(2, 7'b0110011);
            strobe(3, 7'b1110011);
        end
        idle();
        wait_cycles(4);
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(bus.out_valid), 1);
            check("t4_hold_idx", 32'(bus.out_idx), 0);
            check("t4_hold_bcd", 32'(bus.out_bcd), 7);
        end
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        wait_cycles(8);
        check("t4_count", 32'(q_idx.size()), 4);
        if (q_idx.size() >= 4) begin
            check("t4_idx0", 32'(q_idx[0]), 0);
            check("t4_bcd0", 32'(q_bcd[0]), 7);
            check("t4_idx1", 32'(q_idx[1]), 1);
            check("t4_bcd1", 32'(q_bcd[1]), 1);
            check("t4_idx2", 32'(q_idx[2]), 2);
            check("t4_bcd2", 32'(q_bcd[2]), 4);
            check("t4_idx3", 32'(q_idx[3]), 3);
            check("t4_bcd3", 32'(q_bcd[3]), 9);
            check("t4_b2b1", 32'(q_cyc[1]), 32'(q_cyc[0] + 1));
            check("t4_b2b3", 32'(q_cyc[3]), 32'(q_cyc[0] + 3));
        end

        // 5: non-one-hot select pulses sel_err and leaves counters alone
        clear_q();
        strobe(1, 7'b1101101);
        strobe(1, 7'b1101101);
        @(posedge clk); #2;
        bus.seg_in = 7'b1101101; bus.dig_sel = 4'b0110; bus.seg_strobe = 1'b1;
        idle();
        @(negedge clk);
        check("t5_selerr_hi", 32'(bus.sel_err), 1);
        @(negedge clk);
        check("t5_selerr_lo", 32'(bus.sel_err), 0);
        wait_cycles(4);
        check("t5_no_publish", 32'(q_idx.size()), 0);
        strobe(1, 7'b1101101);
        idle();
        wait_cycles(6);
        check("t5_count", 32'(q_idx.size()), 1);
        if (q_idx.size() >= 1) check("t5_bcd", 32'(q_bcd[0]), 2);

        // 6: asynchronous reset with output held and a digit mid-count
        clear_q();
        bus.out_ready = 1'b0;
        repeat (3) strobe(0, 7'b1111110);
        strobe(3, 7'b1011011);
        strobe(3, 7'b1011011);
        idle();
        wait_cycles(4);
        check("t6_pre_valid", 32'(bus.out_valid), 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t6_async");
        wait_cycles(2);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        wait_cycles(2);
        strobe(3, 7'b1011011);
        strobe(3, 7'b1011011);
        idle();
        wait_cycles(6);
        check("t6_fresh_count", 32'(q_idx.size()), 0);
        strobe(3, 7'b1011011);
        idle();
        wait_cycles(6);
        check("t6_publish", 32'(q_idx.size()), 1);
        if (q_idx.size() >= 1) begin
            check("t6_idx", 32'(q_idx[0]), 3);
            check("t6_bcd", 32'(q_bcd[0]), 5);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
